// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, grant ids and RAM latency legality check for mem_access_ctrl
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_t;
  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA = 1'b1;
  localparam int RAM_LAT_MAX = 15;
  function automatic bit ram_lat_ok(int lat, int cnt_w);
    return lat >= 1 && lat <= RAM_LAT_MAX && (1 << cnt_w) > lat;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_arbiter.sv
// mac_arbiter: fetch/data pick plus registered grant owner; MEM_ACCESS_RR_ARB_EN alternates ties
module mac_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic data_req,
  input  logic grant,
  output logic pick,
  output logic grant_id
);
`ifdef MEM_ACCESS_RR_ARB_EN
  logic seen;
  always_ff @(posedge clk or negedge reset)
    if (!reset) seen <= 1'b0;
    else if (grant) seen <= 1'b1;
  // grant_id still names the last completed owner in IDLE, since an abort also clears it
  assign pick = (fetch_req && data_req) ? (seen ? !grant_id : GRANT_FETCH)
              : (data_req ? GRANT_DATA : GRANT_FETCH);
`else
  assign pick = (data_req && !fetch_req) ? GRANT_DATA : GRANT_FETCH;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) grant_id <= GRANT_FETCH;
    else if (grant) grant_id <= pick;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MAR/MDR/RAM transaction sequencer arbitrating fetch vs data; MEM_ACCESS_RR_ARB_EN selects round-robin ties
module mem_access_ctrl #(
  parameter int RAM_LAT = 1,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  output logic fetch_ack,
  input  logic data_req,
  input  logic data_we,
  output logic data_ack,
  output logic pc_out,
  output logic dar_out,
  output logic mar_in,
  output logic r_en,
  output logic w_en,
  output logic mdr_in,
  output logic mdr_out,
  output logic busy,
  output logic grant_id
);
  import mem_ctrl_pkg::*;
  if (!ram_lat_ok(RAM_LAT, CNT_W)) begin : g_bad_lat
    $error("mem_access_ctrl: RAM_LAT must be 1..15 and below 2**CNT_W");
  end
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT > 1 ? RAM_LAT - 2 : 0);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic we_q, pick, grant;
  assign grant = state == IDLE && (fetch_req || data_req);
  mac_arbiter u_arb (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .data_req(data_req),
    .grant(grant),
    .pick(pick),
    .grant_id(grant_id)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      we_q <= grant ? (pick == GRANT_DATA) && data_we : we_q;
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    case (state)
      IDLE: state_d = grant ? ADDR : IDLE;
      ADDR: begin
        state_d = (RAM_LAT > 1) ? WAIT : DONE;
        cnt_d = CNT_LOAD;
      end
      WAIT: begin
        state_d = (cnt == '0) ? DONE : WAIT;
        cnt_d = (cnt == '0) ? cnt : cnt - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // RAM enables stay up for the whole transaction; write data is dropped in DONE
  assign busy = state != IDLE;
  assign mar_in = state == ADDR;
  assign pc_out = mar_in && grant_id == GRANT_FETCH;
  assign dar_out = mar_in && grant_id == GRANT_DATA;
  assign r_en = busy && !we_q;
  assign w_en = busy && we_q;
  assign mdr_out = we_q && (state == ADDR || state == WAIT);
  assign mdr_in = state == DONE && !we_q;
  assign fetch_ack = state == DONE && grant_id == GRANT_FETCH;
  assign data_ack = state == DONE && grant_id == GRANT_DATA;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: checks three RAM latencies (1,3,4) against a transaction-phase model plus fixed vectors
module tb_mem_access_ctrl;
  logic clk = 1'b0, reset = 1'b0, fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [10:0] act [3];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic fa, da, pc, dar, mar, re, we, mi, mo, bsy, gid;
    mem_access_ctrl #(.RAM_LAT(L), .CNT_W(4)) u_dut (
      .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_ack(fa),
      .data_req(data_req), .data_we(data_we), .data_ack(da),
      .pc_out(pc), .dar_out(dar), .mar_in(mar), .r_en(re), .w_en(we),
      .mdr_in(mi), .mdr_out(mo), .busy(bsy), .grant_id(gid)
    );
    assign act[g] = {bsy, gid, pc, dar, mar, re, we, mi, mo, fa, da};
  end
  int ph [3];
  bit own [3], mwe [3], seen [3];
  function automatic int lat_of(int i);
    return i == 0 ? 1 : (i == 1 ? 3 : 4);
  endfunction
  function automatic bit pick_of(int i, bit f, bit d);
    if (f && d) begin
`ifdef MEM_ACCESS_RR_ARB_EN
      return seen[i] ? !own[i] : 1'b0;
`else
      return 1'b0;
`endif
    end
    return d;
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = -1; own[i] = 1'b0; mwe[i] = 1'b0; seen[i] = 1'b0;
    end
  endfunction
  function automatic void model_step(bit f, bit d, bit w);
    for (int i = 0; i < 3; i++)
      if (ph[i] < 0) begin
        if (f || d) begin
          own[i] = pick_of(i, f, d);
          mwe[i] = own[i] && w;
          seen[i] = 1'b1;
          ph[i] = 0;
        end
      end else ph[i] = (ph[i] == lat_of(i)) ? -1 : ph[i] + 1;
  endfunction
  function automatic logic [10:0] exp_of(int i);
    bit b = ph[i] >= 0;
    bit a = ph[i] == 0;
    bit dn = ph[i] == lat_of(i);
    return {b, own[i], a && !own[i], a && own[i], a, b && !mwe[i], b && mwe[i],
            dn && !mwe[i], b && !dn && mwe[i], dn && !own[i], dn && own[i]};
  endfunction
  task automatic chk(string name, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, a, e);
    end
  endtask
  task automatic tick(bit f, bit d, bit w);
    fetch_req = f; data_req = d; data_we = w;
    @(posedge clk);
    if (reset) model_step(f, d, w); else model_reset();
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("model_lat%0d", lat_of(i)), 32'(act[i]), 32'(exp_of(i)));
  endtask
  task automatic drain();
    repeat (6) tick(1'b0, 1'b0, 1'b0);
  endtask
  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("async_reset_lat%0d", lat_of(i)), 32'(act[i]), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask
  typedef struct {bit f; bit d; bit w; logic [10:0] e;} vec_t;
  vec_t tv [15];
  logic [10:0] e3 [5], e4 [5];
  initial begin
    logic [2:0] gids;
    int n, acks, last;
    tv = '{
      '{1'b1, 1'b0, 1'b0, 11'b10101100000}, '{1'b0, 1'b0, 1'b0, 11'b10000101010},
      '{1'b0, 1'b0, 1'b0, 11'b00000000000}, '{1'b0, 1'b1, 1'b1, 11'b11011010100},
      '{1'b0, 1'b0, 1'b0, 11'b11000010001}, '{1'b0, 1'b0, 1'b0, 11'b01000000000},
      '{1'b0, 1'b1, 1'b0, 11'b11011100000}, '{1'b0, 1'b1, 1'b0, 11'b11000101001},
      '{1'b0, 1'b0, 1'b0, 11'b01000000000}, '{1'b1, 1'b0, 1'b0, 11'b10101100000},
      '{1'b1, 1'b0, 1'b0, 11'b10000101010}, '{1'b1, 1'b0, 1'b0, 11'b00000000000},
      '{1'b1, 1'b0, 1'b0, 11'b10101100000}, '{1'b0, 1'b0, 1'b0, 11'b10000101010},
      '{1'b0, 1'b0, 1'b0, 11'b00000000000}};
    e3 = '{11'b11011010100, 11'b11000010100, 11'b11000010100, 11'b11000010001, 11'b01000000000};
    e4 = '{11'b11011100000, 11'b11000100000, 11'b11000100000, 11'b11000100000, 11'b11000101001};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("reset_lat%0d", lat_of(i)), 32'(act[i]), 32'd0);
    reset = 1'b1;
    foreach (tv[k]) begin
      tick(tv[k].f, tv[k].d, tv[k].w);
      chk($sformatf("vec%0d", k), 32'(act[0]), 32'(tv[k].e));
    end
    drain();
    // RAM_LAT=3 store: ADDR, two WAITs holding w_en, DONE with data_ack
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, k == 0, 1'b1);
      chk($sformatf("store3_c%0d", k), 32'(act[1]), 32'(e3[k]));
    end
    drain();
    // RAM_LAT=4 load with data_we toggling after grant
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, k == 0, k[0]);
      chk($sformatf("load4_we_toggle_c%0d", k), 32'(act[2]), 32'(e4[k]));
    end
    drain();
    pulse_reset();
    gids = '0;
    n = 0;
    for (int k = 0; k < 9; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (act[0][6] && n < 3) begin
        gids[n] = act[0][9];
        n++;
      end
    end
    chk("tie_grant_count", 32'(n), 32'd3);
`ifdef MEM_ACCESS_RR_ARB_EN
    chk("tie_grant_order", 32'(gids), 32'b010);
`else
    chk("tie_grant_order", 32'(gids), 32'b000);
`endif
    drain();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("abort_lat%0d", lat_of(i)), 32'(act[i]), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    acks = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      tick(1'b0, 1'b0, 1'b0);
      acks += int'(act[2][1]);
    end
    chk("after_abort_fetch_acks", 32'(acks), 32'd1);
    for (int k = 0; k < 600; k++)
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    drain();
    acks = 0;
    last = -1;
    for (int k = 0; k < 12; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (act[0][1]) begin
        if (last >= 0) chk("fetch_ack_spacing", 32'(k - last), 32'd3);
        last = k;
        acks++;
      end
    end
    chk("continuous_fetch_acks", 32'(acks), 32'd4);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
